// File: rtl/key_event_if.sv
// Key event bundle: the debounced key level going in and the event
// pulses/levels coming out. The slave side is the key_event block itself.
interface key_event_if;
  logic key_i;
  logic press_o;
  logic release_o;
  logic click_o;
  logic long_o;
  logic rep_o;
  logic step_o;
  logic held_o;

  modport master (
    output key_i,
    input  press_o, release_o, click_o, long_o, rep_o, step_o, held_o
  );

  modport slave (
    input  key_i,
    output press_o, release_o, click_o, long_o, rep_o, step_o, held_o
  );
endinterface

// File: rtl/key_event.sv
// Key event generator: turns a debounced key level into single-cycle
// press / release / click / long / repeat pulses plus a registered "step"
// (press or repeat) and a "held" level. One counter is shared between the
// long-press hold time and the repeat interval, so it only ever counts up to
// the larger of the two terminal values.
module key_event #(
  parameter int unsigned     CNT_W    = 26,
  parameter logic [CNT_W-1:0] HOLD_CYC = 26'd50_000_000,
  parameter logic [CNT_W-1:0] REP_CYC  = 26'd10_000_000
) (
  input  logic        clk,
  input  logic        rstn,
  key_event_if.slave  kif
);

  localparam logic [CNT_W-1:0] ONE       = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_CYC - ONE;
  localparam logic [CNT_W-1:0] REP_LAST  = REP_CYC - ONE;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DOWN   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             click_q, click_d;
  logic             long_q, long_d;
  logic             rep_q, rep_d;
  logic             step_q, step_d;
  logic             held_q, held_d;

  // State, counter and all outputs are registered; reset clears everything at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      long_q    <= 1'b0;
      rep_q     <= 1'b0;
      step_q    <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      click_q   <= click_d;
      long_q    <= long_d;
      rep_q     <= rep_d;
      step_q    <= step_d;
      held_q    <= held_d;
    end
  end

  // Next state and pulse decisions; a released key is checked before the
  // terminal count so release always beats long/rep on the same edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    click_d   = 1'b0;
    long_d    = 1'b0;
    rep_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (kif.key_i) begin
          state_d = DOWN;
          cnt_d   = '0;
          press_d = 1'b1;
        end
      end
      DOWN: begin
        if (!kif.key_i) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
          click_d   = 1'b1;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = REPEAT;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      REPEAT: begin
        if (!kif.key_i) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else if (cnt_q == REP_LAST) begin
          cnt_d = '0;
          rep_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    step_d = press_d | rep_d;
    held_d = (state_d != IDLE);
  end

  assign kif.press_o   = press_q;
  assign kif.release_o = release_q;
  assign kif.click_o   = click_q;
  assign kif.long_o    = long_q;
  assign kif.rep_o     = rep_q;
  assign kif.step_o    = step_q;
  assign kif.held_o    = held_q;

endmodule

// File: tb/tb_key_event.sv
// Directed bench for key_event with HOLD_CYC=8, REP_CYC=3. Each scenario
// drives a key pattern, one bit per clock edge (bit i = key sampled at edge
// t0+i), records every output after each edge into per-output bit vectors,
// then compares those vectors to hand-computed masks.
module tb_key_event;
  logic clk;
  logic rstn;
  int   errors;
  int   checks;

  logic [31:0] pv, rv, cv, lv, ev, sv, hv;

  key_event_if kif ();

  key_event #(
    .CNT_W    (26),
    .HOLD_CYC (26'd8),
    .REP_CYC  (26'd3)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .kif  (kif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // All outputs must be zero right now.
  task automatic chk_zero(input string tag);
    chk(tag, {25'd0, kif.press_o, kif.release_o, kif.click_o, kif.long_o,
              kif.rep_o, kif.step_o, kif.held_o}, 32'd0);
  endtask

  // Drive kpat over n edges and record outputs after each edge.
  task automatic run(input logic [31:0] kpat, input int n);
    pv = '0; rv = '0; cv = '0; lv = '0; ev = '0; sv = '0; hv = '0;
    for (int i = 0; i < n; i++) begin
      kif.key_i = kpat[i];
      @(posedge clk);
      #1;
      pv[i] = kif.press_o;
      rv[i] = kif.release_o;
      cv[i] = kif.click_o;
      lv[i] = kif.long_o;
      ev[i] = kif.rep_o;
      sv[i] = kif.step_o;
      hv[i] = kif.held_o;
      $display("edge %0d key=%0b press=%0b release=%0b click=%0b long=%0b rep=%0b step=%0b held=%0b",
               i, kpat[i], pv[i], rv[i], cv[i], lv[i], ev[i], sv[i], hv[i]);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    kif.key_i = 1'b0;
    rstn = 1'b0;

    // 1. Reset held with key toggling: everything stays 0.
    #2;
    chk_zero("reset_initial");
    for (int i = 0; i < 6; i++) begin
      kif.key_i = i[0];
      @(posedge clk);
      #1;
      chk_zero("reset_toggle");
    end
    kif.key_i = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk_zero("idle_after_reset");

    // 2. Short click: key high for 4 edges.
    run(32'h0000_000F, 5);
    chk("s2_press",   pv, 32'h0000_0001);
    chk("s2_step",    sv, 32'h0000_0001);
    chk("s2_release", rv, 32'h0000_0010);
    chk("s2_click",   cv, 32'h0000_0010);
    chk("s2_long",    lv, 32'h0000_0000);
    chk("s2_rep",     ev, 32'h0000_0000);
    chk("s2_held",    hv, 32'h0000_000F);

    // 3. Long press with three repeats.
    run(32'h000F_FFFF, 21);
    chk("s3_press",   pv, 32'h0000_0001);
    chk("s3_long",    lv, 32'h0000_0100);
    chk("s3_rep",     ev, 32'h0002_4800);
    chk("s3_release", rv, 32'h0010_0000);
    chk("s3_click",   cv, 32'h0000_0000);
    chk("s3_step",    sv, 32'h0002_4801);
    chk("s3_step_cnt", $countones(sv), 32'd4);
    chk("s3_held",    hv, 32'h000F_FFFF);

    // 4. Release on the terminal edge: release wins, still a click.
    run(32'h0000_00FF, 9);
    chk("s4_press",   pv, 32'h0000_0001);
    chk("s4_release", rv, 32'h0000_0100);
    chk("s4_click",   cv, 32'h0000_0100);
    chk("s4_long",    lv, 32'h0000_0000);
    chk("s4_held",    hv, 32'h0000_00FF);

    // 5. Reset while held, then restart with key already high.
    run(32'h0000_0FFF, 12);
    chk("s5_long",    lv, 32'h0000_0100);
    chk("s5_rep",     ev, 32'h0000_0800);
    chk("s5_held_pre", kif.held_o, 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk_zero("s5_async_reset");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk_zero("s5_in_reset");
    end
    @(negedge clk);
    rstn = 1'b1;
    run(32'h0000_01FF, 9);
    chk("s5_press",   pv, 32'h0000_0001);
    chk("s5_long2",   lv, 32'h0000_0100);
    chk("s5_norel",   rv, 32'h0000_0000);
    run(32'h0000_0000, 1);
    chk("s5_release", rv, 32'h0000_0001);
    chk("s5_noclick", cv, 32'h0000_0000);

    // 6. Two presses separated by a single low cycle.
    run(32'h0000_7FEF, 16);
    chk("s6_press",   pv, 32'h0000_0021);
    chk("s6_release", rv, 32'h0000_8010);
    chk("s6_click",   cv, 32'h0000_0010);
    chk("s6_long",    lv, 32'h0000_2000);
    chk("s6_rep",     ev, 32'h0000_0000);
    chk("s6_step",    sv, 32'h0000_0021);
    chk("s6_held",    hv, 32'h0000_7FEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
